// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of the 4-digit display.
// Latches one requester's value per dwell window and drives digit scan.
module seg_display_arbiter #(
  parameter int DWELL    = 4096,
  parameter int SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] req_data,
  output logic [3:0]  ack,
  output logic [15:0] disp_value,
  output logic [1:0]  disp_owner,
  output logic        disp_valid,
  output logic        busy,
  output logic [1:0]  digit_sel,
  output logic        digit_tick
);

  localparam int DW = $clog2(DWELL);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  state_t        state;
  state_t        stateNext;
  logic [1:0]    rrPtr;
  logic [1:0]    rrPtrNext;
  logic [1:0]    pick;
  logic          pickOk;
  logic          grant;
  logic [DW-1:0] dwellCnt;
  logic [DW-1:0] dwellNext;
  logic [3:0]    ackNext;
  logic [15:0]   valueNext;
  logic [1:0]    ownerNext;
  logic          validNext;
  logic [SW-1:0] scanCnt;

  // First asserted request at or above rrPtr, modulo 4
  always_comb begin
    pick   = rrPtr;
    pickOk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!pickOk && req[rrPtr + 2'(i)]) begin
        pick   = rrPtr + 2'(i);
        pickOk = 1'b1;
      end
    end
  end

  assign grant = pickOk &&
                 (state == IDLE || dwellCnt == '0);

  // Next-state and next-output decode
  always_comb begin
    stateNext = state;
    dwellNext = dwellCnt;
    rrPtrNext = rrPtr;
    ackNext   = '0;
    valueNext = disp_value;
    ownerNext = disp_owner;
    validNext = disp_valid;
    unique case (1'b1)
      grant: begin
        stateNext = SHOW;
        dwellNext = DWELL_LAST;
        rrPtrNext = pick + 2'd1;
        ackNext   = 4'b0001 << pick;
        valueNext = req_data[{pick, 4'b0000} +: 16];
        ownerNext = pick;
        validNext = 1'b1;
      end
      (state == SHOW && dwellCnt != '0): begin
        dwellNext = dwellCnt - 1'b1;
      end
      (state == SHOW && dwellCnt == '0 && !pickOk): begin
        stateNext = IDLE;
      end
      default: ;
    endcase
  end

  // FSM, pointer, dwell counter and display registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rrPtr      <= '0;
      dwellCnt   <= '0;
      ack        <= '0;
      disp_value <= '0;
      disp_owner <= '0;
      disp_valid <= 1'b0;
    end else begin
      state      <= stateNext;
      rrPtr      <= rrPtrNext;
      dwellCnt   <= dwellNext;
      ack        <= ackNext;
      disp_value <= valueNext;
      disp_owner <= ownerNext;
      disp_valid <= validNext;
    end
  end

  assign busy = (state == SHOW);

  // Free-running digit scan prescaler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scanCnt    <= '0;
      digit_sel  <= '0;
      digit_tick <= 1'b0;
    end else if (scanCnt == SCAN_LAST) begin
      scanCnt    <= '0;
      digit_sel  <= digit_sel + 2'd1;
      digit_tick <= 1'b1;
    end else begin
      scanCnt    <= scanCnt + 1'b1;
      digit_tick <= 1'b0;
    end
  end

endmodule
